// File: rtl/blank_symbol_gen.sv
// Multi-lane blanking symbol generator: BS/BF framing, START VB-ID/Mvid/Maud, VBlank MSA packet, BE framing.
// Optional macro BLANK_SR_EN enables periodic SR substitution in BS sequences (sr_ctr present only then).
module blank_symbol_gen #(
    parameter int LANES     = 4,
    parameter int SR_PERIOD = 512,
    parameter int MSA_MAX   = 36
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sched_blank_en,
    input  logic                 sched_blank_id,
    input  logic [1:0]           sched_blank_state,
    input  logic [1:0]           td_lane_count,
    input  logic                 vbid_field_id,
    input  logic                 vbid_no_audio,
    input  logic [7:0]           mvid_lsb,
    input  logic [7:0]           maud_lsb,
    input  logic [8*LANES-1:0]   sec_steered_out,
    input  logic                 sec_steered_vld,
    output logic [1:0]           blank_steering_state,
    output logic [LANES-1:0]     blank_control_sym_flag,
    output logic [8*LANES-1:0]   blank_symbols
);

    localparam int CNT_W = $clog2(MSA_MAX + 1);
    localparam logic [7:0] K_BS = 8'hBC;
    localparam logic [7:0] K_BF = 8'hBD;
    localparam logic [7:0] K_SR = 8'h1C;
    localparam logic [7:0] K_BE = 8'hBE;
    localparam logic [7:0] K_SS = 8'hDC;
    localparam logic [7:0] K_SE = 8'hDE;

    typedef enum logic [1:0] {
        ST_BLANK = 2'b00,
        ST_BS    = 2'b01,
        ST_START = 2'b10,
        ST_BE    = 2'b11
    } blank_state_t;

    typedef enum logic [1:0] {
        MSA_SS0  = 2'b00,
        MSA_SS1  = 2'b01,
        MSA_DATA = 2'b10
    } msa_state_t;

    logic [7:0]         r_phase, w_phaseNxt, w_phase, w_k;
    logic [1:0]         r_prevState, w_prevNxt, w_idx;
    msa_state_t         r_msaState, w_msaStateNxt;
    logic [CNT_W-1:0]   r_msaCnt, w_msaCntNxt;
    logic               r_msaDone, w_msaDoneNxt;
    logic [2:0]         w_active;
    logic [7:0]         w_startLen;
    logic [7:0]         w_sym;
    logic               w_flag, w_useMsa, w_srHit, w_srAdvance;
    logic [1:0]         w_steer;
    logic [8*LANES-1:0] w_symbolsNxt;
    logic [LANES-1:0]   w_flagNxt;

`ifdef BLANK_SR_EN
    localparam int SR_W = (SR_PERIOD > 1) ? $clog2(SR_PERIOD) : 1;
    logic [SR_W-1:0] r_srCtr;
    assign w_srHit = (r_srCtr == '0);
`else
    assign w_srHit = 1'b0;
`endif

    // Active lane count (reserved code means one lane) capped at the physical width; START repetition follows from it.
    always_comb begin
        case (td_lane_count)
            2'b01:   w_active = 3'd2;
            2'b11:   w_active = 3'd4;
            default: w_active = 3'd1;
        endcase
        if (w_active > 3'(LANES)) w_active = 3'(LANES);
        case (w_active)
            3'd4:    w_startLen = 8'd3;
            3'd2:    w_startLen = 8'd6;
            default: w_startLen = 8'd12;
        endcase
    end

    always_comb begin
        w_phase       = (sched_blank_state != r_prevState) ? 8'd0 : r_phase;
        w_idx         = w_phase[1:0];
        w_k           = w_phase % 8'd3;
        w_phaseNxt    = r_phase;
        w_prevNxt     = r_prevState;
        w_msaStateNxt = r_msaState;
        w_msaCntNxt   = r_msaCnt;
        w_msaDoneNxt  = r_msaDone;
        w_sym         = 8'h00;
        w_flag        = 1'b0;
        w_steer       = 2'b00;
        w_useMsa      = 1'b0;
        w_srAdvance   = 1'b0;
        if (sched_blank_en) begin
            w_prevNxt = sched_blank_state;
            case (blank_state_t'(sched_blank_state))
                ST_BS: begin
                    w_flag     = 1'b1;
                    w_phaseNxt = {6'd0, w_idx + 2'd1};
                    if (w_idx == 2'd1 || w_idx == 2'd2) w_sym = K_BF;
                    else                                w_sym = w_srHit ? K_SR : K_BS;
                    if (w_idx == 2'd3) begin
                        w_steer     = 2'b01;
                        w_srAdvance = 1'b1;
                    end
                end
                ST_BE: begin
                    w_flag     = 1'b1;
                    w_phaseNxt = {6'd0, w_idx + 2'd1};
                    w_sym      = (w_idx == 2'd1 || w_idx == 2'd2) ? K_BF : K_BE;
                    if (w_idx == 2'd3) w_steer = 2'b01;
                end
                ST_START: begin
                    if (w_phase < w_startLen) begin
                        case (w_k[1:0])
                            2'd0:    w_sym = {4'b0, vbid_no_audio, 1'b0, vbid_field_id, ~sched_blank_id};
                            2'd1:    w_sym = mvid_lsb;
                            default: w_sym = maud_lsb;
                        endcase
                    end
                    // Parking at 0xFF after the last cycle keeps a mid-START lane change from re-pulsing or stalling.
                    if (w_phase >= w_startLen - 8'd1) begin
                        if (w_phase != 8'hFF) w_steer = 2'b01;
                        w_phaseNxt = 8'hFF;
                    end else begin
                        w_phaseNxt = w_phase + 8'd1;
                    end
                end
                default: begin
                    w_phaseNxt = (w_phase == 8'hFF) ? w_phase : w_phase + 8'd1;
                    if (sched_blank_id) begin
                        w_msaStateNxt = MSA_SS0;
                        w_msaCntNxt   = '0;
                        w_msaDoneNxt  = 1'b0;
                    end else if (!r_msaDone) begin
                        case (r_msaState)
                            MSA_SS0: begin
                                w_sym = K_SS; w_flag = 1'b1; w_steer = 2'b10;
                                w_msaStateNxt = MSA_SS1;
                            end
                            MSA_SS1: begin
                                w_sym = K_SS; w_flag = 1'b1; w_steer = 2'b10;
                                w_msaStateNxt = MSA_DATA;
                            end
                            MSA_DATA: begin
                                if (sec_steered_vld && r_msaCnt != CNT_W'(MSA_MAX)) begin
                                    w_useMsa    = 1'b1;
                                    w_steer     = 2'b10;
                                    w_msaCntNxt = r_msaCnt + 1'b1;
                                end else begin
                                    w_sym        = K_SE;
                                    w_flag       = 1'b1;
                                    w_msaDoneNxt = 1'b1;
                                end
                            end
                            default: w_msaStateNxt = MSA_SS0;
                        endcase
                    end
                end
            endcase
        end
        w_symbolsNxt = '0;
        w_flagNxt    = '0;
        for (int i = 0; i < LANES; i++) begin
            if (3'(i) < w_active) begin
                w_symbolsNxt[8*i +: 8] = w_useMsa ? sec_steered_out[8*i +: 8] : w_sym;
                w_flagNxt[i]           = w_flag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase                <= '0;
            r_prevState            <= 2'b00;
            r_msaState             <= MSA_SS0;
            r_msaCnt               <= '0;
            r_msaDone              <= 1'b0;
            blank_steering_state   <= 2'b00;
            blank_control_sym_flag <= '0;
            blank_symbols          <= '0;
        end else begin
            r_phase                <= w_phaseNxt;
            r_prevState            <= w_prevNxt;
            r_msaState             <= w_msaStateNxt;
            r_msaCnt               <= w_msaCntNxt;
            r_msaDone              <= w_msaDoneNxt;
            blank_steering_state   <= w_steer;
            blank_control_sym_flag <= w_flagNxt;
            blank_symbols          <= w_symbolsNxt;
        end
    end

`ifdef BLANK_SR_EN
    // Wraps naturally because SR_PERIOD is a power of two.
    always_ff @(posedge clk) begin
        if (rst)              r_srCtr <= '0;
        else if (w_srAdvance) r_srCtr <= r_srCtr + 1'b1;
    end
`endif

endmodule

// File: tb/tb_blank_symbol_gen.sv
// Self-checking bench for blank_symbol_gen: per-cycle model comparison plus literal pinned expectations.
// Honours BLANK_SR_EN the same way as the design.
module tb_blank_symbol_gen;

    localparam int LANES     = 4;
    localparam int SR_PERIOD = 512;
    localparam int MSA_MAX   = 36;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 sched_blank_en;
    logic                 sched_blank_id;
    logic [1:0]           sched_blank_state;
    logic [1:0]           td_lane_count;
    logic                 vbid_field_id;
    logic                 vbid_no_audio;
    logic [7:0]           mvid_lsb;
    logic [7:0]           maud_lsb;
    logic [8*LANES-1:0]   sec_steered_out;
    logic                 sec_steered_vld;
    logic [1:0]           blank_steering_state;
    logic [LANES-1:0]     blank_control_sym_flag;
    logic [8*LANES-1:0]   blank_symbols;

    int errors = 0;
    int checks = 0;

    blank_symbol_gen #(.LANES(LANES), .SR_PERIOD(SR_PERIOD), .MSA_MAX(MSA_MAX)) dut (
        .clk(clk), .rst(rst),
        .sched_blank_en(sched_blank_en), .sched_blank_id(sched_blank_id),
        .sched_blank_state(sched_blank_state), .td_lane_count(td_lane_count),
        .vbid_field_id(vbid_field_id), .vbid_no_audio(vbid_no_audio),
        .mvid_lsb(mvid_lsb), .maud_lsb(maud_lsb),
        .sec_steered_out(sec_steered_out), .sec_steered_vld(sec_steered_vld),
        .blank_steering_state(blank_steering_state),
        .blank_control_sym_flag(blank_control_sym_flag),
        .blank_symbols(blank_symbols)
    );

    always #5 clk = ~clk;

    // Model: cycles-in-state counter, completed BS sequence count and MSA progress.
    bit                 mValid = 1'b0;
    int                 mPhase, mSeq, mMsaStep, mMsaBytes;
    bit                 mMsaDone;
    logic [1:0]         mPrev;
    logic [8*LANES-1:0] expSym;
    logic [LANES-1:0]   expFlag;
    logic [1:0]         expSteer;

    always @(posedge clk) begin
        int ph, p, act, reps;
        logic [7:0] sym;
        bit flag, useMsa, srHit;
        logic [1:0] steer;
        sym = 8'h00; flag = 1'b0; useMsa = 1'b0; steer = 2'b00;
        act = (td_lane_count == 2'b11) ? 4 : (td_lane_count == 2'b01) ? 2 : 1;
        if (act > LANES) act = LANES;
        if (rst) begin
            mPhase = 0; mSeq = 0; mMsaStep = 0; mMsaBytes = 0; mMsaDone = 1'b0; mPrev = 2'b00;
        end else if (sched_blank_en) begin
            ph = (sched_blank_state != mPrev) ? 0 : mPhase;
            mPrev = sched_blank_state;
            mPhase = ph + 1;
            p = ph % 4;
            case (sched_blank_state)
                2'b01: begin
`ifdef BLANK_SR_EN
                    srHit = (mSeq % SR_PERIOD) == 0;
`else
                    srHit = 1'b0;
`endif
                    flag = 1'b1;
                    sym = (p == 1 || p == 2) ? 8'hBD : (srHit ? 8'h1C : 8'hBC);
                    if (p == 3) begin steer = 2'b01; mSeq++; end
                end
                2'b11: begin
                    flag = 1'b1;
                    sym = (p == 1 || p == 2) ? 8'hBD : 8'hBE;
                    if (p == 3) steer = 2'b01;
                end
                2'b10: begin
                    reps = 4 / act;
                    if (ph < 3 * reps) begin
                        if (ph % 3 == 0)      sym = {4'b0, vbid_no_audio, 1'b0, vbid_field_id, ~sched_blank_id};
                        else if (ph % 3 == 1) sym = mvid_lsb;
                        else                  sym = maud_lsb;
                    end
                    if (ph == 3 * reps - 1) steer = 2'b01;
                end
                default: begin
                    if (sched_blank_id) begin
                        mMsaStep = 0; mMsaBytes = 0; mMsaDone = 1'b0;
                    end else if (!mMsaDone) begin
                        if (mMsaStep < 2) begin
                            sym = 8'hDC; flag = 1'b1; steer = 2'b10; mMsaStep++;
                        end else if (sec_steered_vld && mMsaBytes < MSA_MAX) begin
                            useMsa = 1'b1; steer = 2'b10; mMsaBytes++;
                        end else begin
                            sym = 8'hDE; flag = 1'b1; mMsaDone = 1'b1;
                        end
                    end
                end
            endcase
        end
        expSym = '0; expFlag = '0; expSteer = steer;
        if (!rst && sched_blank_en) begin
            for (int i = 0; i < act; i++) begin
                expSym[8*i +: 8] = useMsa ? sec_steered_out[8*i +: 8] : sym;
                expFlag[i] = flag;
            end
        end
        mValid = 1'b1;
    end

    always @(negedge clk) begin
        if (mValid) begin
            checks++;
            if (blank_symbols !== expSym || blank_control_sym_flag !== expFlag ||
                blank_steering_state !== expSteer) begin
                errors++;
                $display("[TB] FAIL model t=%0t: sym=%h flag=%b steer=%b, expected sym=%h flag=%b steer=%b",
                         $time, blank_symbols, blank_control_sym_flag, blank_steering_state,
                         expSym, expFlag, expSteer);
            end
        end
    end

    task automatic applyStimulus(input bit en, input logic [1:0] st, input bit id,
                                 input logic [1:0] lanes, input bit vld);
        sched_blank_en    = en;
        sched_blank_state = st;
        sched_blank_id    = id;
        td_lane_count     = lanes;
        sec_steered_vld   = vld;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] sym,
                               input logic [3:0] flag, input logic [1:0] steer);
        checks++;
        if (blank_symbols !== sym || blank_control_sym_flag !== flag || blank_steering_state !== steer) begin
            errors++;
            $display("[TB] FAIL %s: sym=%h flag=%b steer=%b, expected sym=%h flag=%b steer=%b",
                     name, blank_symbols, blank_control_sym_flag, blank_steering_state, sym, flag, steer);
        end
    endtask

    initial begin
        logic [7:0] srSym, startSeq [3];
`ifdef BLANK_SR_EN
        srSym = 8'h1C;
`else
        srSym = 8'hBC;
`endif
        startSeq[0] = 8'h08; startSeq[1] = 8'h5A; startSeq[2] = 8'h3C;
        rst = 1'b1; vbid_field_id = 1'b0; vbid_no_audio = 1'b1;
        mvid_lsb = 8'h5A; maud_lsb = 8'h3C; sec_steered_out = 32'h11223344;
        applyStimulus(1'b1, 2'b01, 1'b0, 2'b11, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b0, 2'b11, 1'b0);
        checkOutput("reset", 32'h0, 4'h0, 2'b00);
        rst = 1'b0;

        // First BS sequence on 4 lanes
        applyStimulus(1'b1, 2'b01, 1'b0, 2'b11, 1'b0);
        checkOutput("bs1_p0", {4{srSym}}, 4'hF, 2'b00);
        applyStimulus(1'b1, 2'b01, 1'b0, 2'b11, 1'b0);
        checkOutput("bs1_p1", {4{8'hBD}}, 4'hF, 2'b00);
        applyStimulus(1'b1, 2'b01, 1'b0, 2'b11, 1'b0);
        checkOutput("bs1_p2", {4{8'hBD}}, 4'hF, 2'b00);
        applyStimulus(1'b1, 2'b01, 1'b0, 2'b11, 1'b0);
        checkOutput("bs1_p3", {4{srSym}}, 4'hF, 2'b01);
        for (int s = 0; s < SR_PERIOD - 1; s++) begin
            applyStimulus(1'b1, 2'b01, 1'b0, 2'b11, 1'b0);
            if (s == 0) checkOutput("bs2_p0", {4{8'hBC}}, 4'hF, 2'b00);
            for (int c = 0; c < 3; c++) applyStimulus(1'b1, 2'b01, 1'b0, 2'b11, 1'b0);
        end
        applyStimulus(1'b1, 2'b01, 1'b0, 2'b11, 1'b0);
        checkOutput("bs513_p0", {4{srSym}}, 4'hF, 2'b00);
        for (int c = 0; c < 3; c++) applyStimulus(1'b1, 2'b01, 1'b0, 2'b11, 1'b0);
        checkOutput("bs513_p3", {4{srSym}}, 4'hF, 2'b01);

        // START on one lane, then on four lanes
        for (int c = 0; c < 12; c++) begin
            applyStimulus(1'b1, 2'b10, 1'b1, 2'b00, 1'b0);
            checkOutput($sformatf("start1_%0d", c), {24'h0, startSeq[c % 3]}, 4'h0,
                        (c == 11) ? 2'b01 : 2'b00);
        end
        applyStimulus(1'b1, 2'b10, 1'b1, 2'b00, 1'b0);
        checkOutput("start1_after", 32'h0, 4'h0, 2'b00);
        applyStimulus(1'b1, 2'b00, 1'b1, 2'b11, 1'b0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 2'b10, 1'b1, 2'b11, 1'b0);
            checkOutput($sformatf("start4_%0d", c), {4{startSeq[c]}}, 4'h0, (c == 2) ? 2'b01 : 2'b00);
        end

        // VBlank MSA packet
        applyStimulus(1'b1, 2'b00, 1'b1, 2'b11, 1'b0);
        applyStimulus(1'b1, 2'b00, 1'b0, 2'b11, 1'b0);
        checkOutput("msa_ss0", {4{8'hDC}}, 4'hF, 2'b10);
        applyStimulus(1'b1, 2'b00, 1'b0, 2'b11, 1'b0);
        checkOutput("msa_ss1", {4{8'hDC}}, 4'hF, 2'b10);
        applyStimulus(1'b1, 2'b00, 1'b0, 2'b11, 1'b1);
        checkOutput("msa_d0", 32'h11223344, 4'h0, 2'b10);
        applyStimulus(1'b1, 2'b00, 1'b0, 2'b11, 1'b1);
        checkOutput("msa_d1", 32'h11223344, 4'h0, 2'b10);
        applyStimulus(1'b1, 2'b00, 1'b0, 2'b11, 1'b0);
        checkOutput("msa_se", {4{8'hDE}}, 4'hF, 2'b00);
        applyStimulus(1'b1, 2'b00, 1'b0, 2'b11, 1'b0);
        checkOutput("msa_done", 32'h0, 4'h0, 2'b00);

        // HBlank restart, then reset mid-MSA
        applyStimulus(1'b1, 2'b00, 1'b1, 2'b11, 1'b0);
        applyStimulus(1'b1, 2'b00, 1'b0, 2'b11, 1'b0);
        checkOutput("msa_restart", {4{8'hDC}}, 4'hF, 2'b10);
        applyStimulus(1'b1, 2'b00, 1'b0, 2'b11, 1'b0);
        applyStimulus(1'b1, 2'b00, 1'b0, 2'b11, 1'b1);
        rst = 1'b1;
        applyStimulus(1'b1, 2'b00, 1'b0, 2'b11, 1'b1);
        checkOutput("rst_mid_msa", 32'h0, 4'h0, 2'b00);
        rst = 1'b0;
        applyStimulus(1'b1, 2'b00, 1'b0, 2'b11, 1'b0);
        checkOutput("msa_after_rst", {4{8'hDC}}, 4'hF, 2'b10);

        // MSA_MAX forces SE while valid stays high
        applyStimulus(1'b1, 2'b00, 1'b1, 2'b11, 1'b0);
        for (int c = 0; c < 2 + MSA_MAX; c++) applyStimulus(1'b1, 2'b00, 1'b0, 2'b11, 1'b1);
        checkOutput("msa_last_byte", 32'h11223344, 4'h0, 2'b10);
        applyStimulus(1'b1, 2'b00, 1'b0, 2'b11, 1'b1);
        checkOutput("msa_max_se", {4{8'hDE}}, 4'hF, 2'b00);

        // Two lanes: partial BS, BE framing, enable gap
        applyStimulus(1'b1, 2'b01, 1'b0, 2'b01, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b0, 2'b01, 1'b0);
        applyStimulus(1'b1, 2'b11, 1'b0, 2'b01, 1'b0);
        checkOutput("be_p0", {16'h0, 8'hBE, 8'hBE}, 4'h3, 2'b00);
        applyStimulus(1'b1, 2'b11, 1'b0, 2'b01, 1'b0);
        checkOutput("be_p1", {16'h0, 8'hBD, 8'hBD}, 4'h3, 2'b00);
        applyStimulus(1'b1, 2'b11, 1'b0, 2'b01, 1'b0);
        applyStimulus(1'b1, 2'b11, 1'b0, 2'b01, 1'b0);
        checkOutput("be_p3", {16'h0, 8'hBE, 8'hBE}, 4'h3, 2'b01);
        applyStimulus(1'b1, 2'b11, 1'b0, 2'b01, 1'b0);
        applyStimulus(1'b1, 2'b11, 1'b0, 2'b01, 1'b0);
        applyStimulus(1'b0, 2'b11, 1'b0, 2'b01, 1'b0);
        checkOutput("be_disabled", 32'h0, 4'h0, 2'b00);
        applyStimulus(1'b1, 2'b11, 1'b0, 2'b01, 1'b0);
        checkOutput("be_resume_p2", {16'h0, 8'hBD, 8'hBD}, 4'h3, 2'b00);
        applyStimulus(1'b1, 2'b11, 1'b0, 2'b01, 1'b0);
        checkOutput("be_resume_p3", {16'h0, 8'hBE, 8'hBE}, 4'h3, 2'b01);

        // New BS sequence on four lanes after the partial one
        applyStimulus(1'b1, 2'b01, 1'b0, 2'b11, 1'b0);
        for (int c = 0; c < 4; c++) applyStimulus(1'b1, 2'b01, 1'b0, 2'b11, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 2'b11, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
